// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: redirect-select and fetch FSM encodings shared with the control unit
package pc_fetch_unit_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_JR     = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10
    } fetch_state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next.sv
// pc_next_calc: combinational next-PC adder/mux, reusable by the pipelined core
module pc_next_calc
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_STEP = 32'd1
) (
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_pc_sel,
    input  logic        i_branch_take,
    input  logic [3:0]  i_sig_ext_h,
    input  logic [27:0] i_sig_ext_l,
    input  logic [31:0] i_reg_target,
    output logic [31:0] o_pc_next
);

    logic [31:0] w_seq;

    assign w_seq = i_pc + PC_STEP;

    // Branch offset is in words and added to the already-incremented PC; all sums wrap mod 2^32
    always_comb begin
        o_pc_next = (i_pc_sel == PC_SEL_BRANCH) ? (i_branch_take ? w_seq + sext16(i_sig_ext_l[15:0]) : w_seq) :
                    (i_pc_sel == PC_SEL_JUMP)   ? {i_sig_ext_h, i_sig_ext_l} :
                    (i_pc_sel == PC_SEL_JR)     ? i_reg_target :
                                                  w_seq;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and request/acknowledge instruction fetch sequencer
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sig_ext_h,
    input  logic [27:0] sig_ext_l,
    input  logic [1:0]  pc_sel,
    input  logic        branch_take,
    input  logic [31:0] reg_target,
    input  logic        next_en,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_link
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_imem_req;
    logic [31:0]  w_pc_next;
    logic         w_ack;
    logic         w_advance;

    // An ack only counts while a request is outstanding, so stray acks in BOOT/ISSUE are dropped
    assign w_ack     = imem_ack & r_imem_req;
    assign w_advance = (r_state == ST_ISSUE) & next_en & ~stall;

    pc_next_calc #(.PC_STEP(PC_STEP)) u_next (
        .i_pc          (r_pc),
        .i_pc_sel      (pc_sel),
        .i_branch_take (branch_take),
        .i_sig_ext_h   (sig_ext_h),
        .i_sig_ext_l   (sig_ext_l),
        .i_reg_target  (reg_target),
        .o_pc_next     (w_pc_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_next;
    end

    // Next state: BOOT lasts one cycle, FETCH waits for ack, ISSUE leaves only on unstalled next_en
    always_comb begin
        w_state_next = (r_state == ST_BOOT)  ? ST_FETCH :
                       (r_state == ST_FETCH) ? (w_ack ? ST_ISSUE : ST_FETCH) :
                       (w_advance ? ST_FETCH : ST_ISSUE);
    end

    // Datapath registers: request follows the FETCH state, instruction captured on ack, PC on retire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_imem_req <= 1'b0;
        end else begin
            r_imem_req <= (w_state_next == ST_FETCH);
            if (r_state == ST_FETCH && w_ack) r_instr <= imem_rdata;
            if (w_advance) r_pc <= w_pc_next;
        end
    end

    // Outputs are all driven from registers except the link adder
    always_comb begin
        imem_req    = r_imem_req;
        imem_addr   = r_pc;
        instr       = r_instr;
        instr_valid = (r_state == ST_ISSUE);
        pc          = r_pc;
        pc_link     = r_pc + PC_STEP;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized fetch/redirect stimulus checked against a transaction-level PC model
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sig_ext_h = '0;
    logic [27:0] sig_ext_l = '0;
    logic [1:0]  pc_sel = '0;
    logic        branch_take = 1'b0;
    logic [31:0] reg_target = '0;
    logic        next_en = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_link;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .sig_ext_h   (sig_ext_h),
        .sig_ext_l   (sig_ext_l),
        .pc_sel      (pc_sel),
        .branch_take (branch_take),
        .reg_target  (reg_target),
        .next_en     (next_en),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_link     (pc_link)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference next-PC from the architectural rules: word-addressed, wrap mod 2^32
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] sel, input logic bt,
                                               input logic [3:0] h, input logic [27:0] l, input logic [31:0] rt);
        logic [31:0] off;
        off = {{16{l[15]}}, l[15:0]};
        case (sel)
            2'b00:   return p + 32'd1;
            2'b01:   return bt ? p + 32'd1 + off : p + 32'd1;
            2'b10:   return {h, l};
            default: return rt;
        endcase
    endfunction

    // Wait for a request, hold the memory off for w cycles, then ack with the word at exp_pc
    task automatic fetch(input int w);
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("imem_addr", imem_addr, exp_pc);
        chk("pc_fetch", pc, exp_pc);
        chk("valid_in_fetch", 32'(instr_valid), 32'd0);
        repeat (w) begin
            @(negedge clk);
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, exp_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(exp_pc);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        exp_instr  = mem_word(exp_pc);
        chk("instr", instr, exp_instr);
        chk("valid", 32'(instr_valid), 32'd1);
        chk("req_drop", 32'(imem_req), 32'd0);
        chk("pc_link", pc_link, exp_pc + 32'd1);
    endtask

    // Optional stray ack, nstall cycles of stall+next_en, then an unstalled next_en pulse
    task automatic issue(input logic [1:0] sel, input logic bt, input logic [3:0] h, input logic [27:0] l,
                         input logic [31:0] rt, input int nstall, input bit stray);
        pc_sel      = sel;
        branch_take = bt;
        sig_ext_h   = h;
        sig_ext_l   = l;
        reg_target  = rt;
        if (stray) begin
            imem_ack   = 1'b1;
            imem_rdata = ~exp_instr;
            @(negedge clk);
            imem_ack = 1'b0;
            chk("stray_instr", instr, exp_instr);
            chk("stray_valid", 32'(instr_valid), 32'd1);
        end
        next_en = 1'b1;
        stall   = 1'b1;
        for (int i = 0; i < nstall; i++) begin
            @(negedge clk);
            chk("stall_pc", pc, exp_pc);
            chk("stall_instr", instr, exp_instr);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        next_en = 1'b0;
        exp_pc  = model_next(exp_pc, sel, bt, h, l, rt);
        chk("valid_drop", 32'(instr_valid), 32'd0);
        chk("pc_adv", pc, exp_pc);
        chk("req_new", 32'(imem_req), 32'd1);
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        exp_pc    = 32'h0;
        exp_instr = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_link", pc_link, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("boot_req", 32'(imem_req), 32'd1);

        fetch(2);
        issue(PC_SEL_SEQ, 1'b0, 4'h0, 28'h0, 32'h0, 0, 1'b0);
        fetch(2);
        issue(PC_SEL_SEQ, 1'b0, 4'h0, 28'h0, 32'h0, 0, 1'b0);
        chk("seq_addr2", imem_addr, 32'h2);
        fetch(2);

        issue(PC_SEL_JUMP, 1'b0, 4'h0, 28'h10, 32'h0, 0, 1'b0);
        fetch(0);
        issue(PC_SEL_BRANCH, 1'b1, 4'h0, 28'h000FFFC, 32'h0, 0, 1'b0);
        chk("branch_taken", imem_addr, 32'h0000_000D);
        fetch(1);
        issue(PC_SEL_JUMP, 1'b0, 4'h0, 28'h10, 32'h0, 0, 1'b0);
        fetch(0);
        issue(PC_SEL_BRANCH, 1'b0, 4'h0, 28'h000FFFC, 32'h0, 0, 1'b0);
        chk("branch_not_taken", imem_addr, 32'h0000_0011);
        fetch(1);
        issue(PC_SEL_JUMP, 1'b0, 4'hA, 28'h0000123, 32'h0, 0, 1'b0);
        chk("jump_addr", imem_addr, 32'hA000_0123);
        fetch(3);
        issue(PC_SEL_JR, 1'b0, 4'h0, 28'h0, 32'hFFFF_FFFF, 0, 1'b0);
        chk("jr_addr", imem_addr, 32'hFFFF_FFFF);
        fetch(0);
        issue(PC_SEL_SEQ, 1'b0, 4'h0, 28'h0, 32'h0, 0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);
        fetch(1);
        issue(PC_SEL_SEQ, 1'b0, 4'h0, 28'h0, 32'h0, 3, 1'b1);
        chk("stall_once", pc, 32'h1);

        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        chk("late_ack_addr", imem_addr, 32'h0);
        exp_pc    = 32'h0;
        exp_instr = 32'h0;

        for (int n = 0; n < 40; n++) begin
            fetch(int'($urandom_range(0, 3)));
            r1 = $urandom;
            r2 = $urandom;
            issue(r1[1:0], r1[2], r1[7:4], r2[27:0], $urandom, int'($urandom_range(0, 2)), r1[3]);
        end
        fetch(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
